uart_bus_master: RTL and testbench

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_master_if.sv | 20 ++
 rtl/uart_bus_master.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_master_if.sv
// Bus side of the UART bus master: word address, write data, registered read
// data and one-cycle strobes.
interface uart_bus_master_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        MemRead;
  logic        MemWrite;
  logic        peri_addr;

  modport master (
    output Address, Write_data, MemRead, MemWrite, peri_addr,
    input  Read_data
  );

  modport slave (
    input  Address, Write_data, MemRead, MemWrite, peri_addr,
    output Read_data
  );
endinterface

// File: rtl/uart_bus_master.sv
// UART-to-bus bridge. Receives 'R'/'W' command frames over 8N1 serial,
// performs one bus access, and answers with 'K', the read word or '?'.
module uart_bus_master #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic tx,
  output logic busy,
  uart_bus_master_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CLKS);

  // ---------------------------------------------------------------- rx sync
  logic rx_m_q, rx_s_q, rx_p_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
    end
  end

  // ---------------------------------------------------------------- rx fsm
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;

  rx_st_e        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_vld, rx_ferr;

  // Receiver: mid-bit sampling, LSB first; flags good bytes and framing errors.
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_vld   = 1'b0;
    rx_ferr  = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_p_q && !rx_s_q) rx_st_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // a line already back high at mid-start is a glitch
          rx_st_d  = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_st_d  = RX_IDLE;
          rx_vld   = rx_s_q;
          rx_ferr  = !rx_s_q;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
    end
  end

  // ---------------------------------------------------------------- cmd fsm
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WRITE, S_READ, S_CAPTURE, S_RESP
  } st_e;

  st_e           st_q, st_d;
  logic [1:0]    idx_q, idx_d;
  logic          is_wr_q, is_wr_d;
  logic          step_q, step_d;
  logic [31:0]   sa_q, sa_d;       // address being assembled
  logic [31:0]   sw_q, sw_d;       // write data being assembled
  logic [31:0]   addr_q, addr_d;   // bus-facing, only changes at access start
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   resp_q, resp_d;   // response bytes, next one in [31:24]
  logic [2:0]    resp_n_q, resp_n_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    tx_sh_q, tx_sh_d; // {stop, data, start}; all ones when idle
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_act_q, tx_act_d;
  logic          load_byte;

  // Command sequencing, bus access timing and response transmitter.
  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    is_wr_d   = is_wr_q;
    step_d    = step_q;
    sa_d      = sa_q;
    sw_d      = sw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
    resp_n_d  = resp_n_q;
    timer_d   = '0;
    tx_sh_d   = tx_sh_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_act_d  = tx_act_q;
    load_byte = 1'b0;
    case (st_q)
      S_IDLE: begin
        idx_d  = '0;
        step_d = 1'b0;
        if (rx_vld) begin
          if (rx_sh_q == 8'h52 || rx_sh_q == 8'h57) begin
            is_wr_d = (rx_sh_q == 8'h57);
            st_d    = S_ADDR;
          end else begin
            resp_d   = {8'h3F, 24'h0};
            resp_n_d = 3'd1;
            st_d     = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (rx_ferr) begin
          st_d = S_IDLE;
        end else if (rx_vld) begin
          sa_d  = {sa_q[23:0], rx_sh_q};
          idx_d = idx_q + 1'b1;
          if (idx_q == 2'd3) begin
            if (is_wr_q) begin
              st_d = S_DATA;
            end else begin
              addr_d = {sa_q[23:0], rx_sh_q};
              st_d   = S_READ;
            end
          end
        end else if (timer_q >= TO_LIMIT) begin
          st_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          st_d = S_IDLE;
        end else if (rx_vld) begin
          sw_d  = {sw_q[23:0], rx_sh_q};
          idx_d = idx_q + 1'b1;
          if (idx_q == 2'd3) begin
            addr_d  = sa_q;
            wdata_d = {sw_q[23:0], rx_sh_q};
            st_d    = S_WRITE;
          end
        end else if (timer_q >= TO_LIMIT) begin
          st_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WRITE: begin
        // first cycle settles Address/Write_data, second carries the strobe
        if (!step_q) begin
          step_d = 1'b1;
        end else begin
          step_d   = 1'b0;
          resp_d   = {8'h4B, 24'h0};
          resp_n_d = 3'd1;
          st_d     = S_RESP;
        end
      end
      S_READ: begin
        if (!step_q) begin
          step_d = 1'b1;
        end else begin
          step_d = 1'b0;
          st_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        resp_d   = bus.Read_data;
        resp_n_d = 3'd4;
        st_d     = S_RESP;
      end
      S_RESP: begin
        if (!tx_act_q) begin
          load_byte = 1'b1;
        end else if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            if (resp_n_q != 3'd0) begin
              load_byte = 1'b1;  // next start bit follows the stop bit directly
            end else begin
              tx_act_d = 1'b0;
              tx_sh_d  = '1;
              st_d     = S_IDLE;
            end
          end else begin
            tx_sh_d  = {1'b1, tx_sh_q[9:1]};
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
    if (load_byte) begin
      tx_sh_d  = {1'b1, resp_q[31:24], 1'b0};
      resp_d   = {resp_q[23:0], 8'h00};
      resp_n_d = resp_n_q - 1'b1;
      tx_act_d = 1'b1;
      tx_cnt_d = '0;
      tx_bit_d = '0;
    end
  end

  // Command/transmit state register; reset drops any access or byte in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= S_IDLE;
      idx_q    <= '0;
      is_wr_q  <= 1'b0;
      step_q   <= 1'b0;
      sa_q     <= '0;
      sw_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      resp_n_q <= '0;
      timer_q  <= '0;
      tx_sh_q  <= '1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_act_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      idx_q    <= idx_d;
      is_wr_q  <= is_wr_d;
      step_q   <= step_d;
      sa_q     <= sa_d;
      sw_q     <= sw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      resp_n_q <= resp_n_d;
      timer_q  <= timer_d;
      tx_sh_q  <= tx_sh_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_act_q <= tx_act_d;
    end
  end

  assign tx             = tx_sh_q[0];
  assign busy           = (st_q != S_IDLE);
  assign bus.Address    = addr_q;
  assign bus.Write_data = wdata_q;
  assign bus.MemWrite   = (st_q == S_WRITE) && step_q;
  assign bus.MemRead    = (st_q == S_READ) && step_q;
  assign bus.peri_addr  = (addr_q[31:28] == 4'h4);
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a registered-read RAM responder.
module tb_uart_bus_master;
  localparam int CPB = 16;
  localparam int BYTE_CLKS = 10 * CPB;

  logic clk = 1'b0;
  logic reset, rx;
  logic tx, busy;
  uart_bus_master_if bus_if();

  uart_bus_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(2000)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .busy(busy), .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // registered-read RAM, indexed by a few address bits
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
      mem[7'h4C] <= 32'h1234_5678;
      mem[7'h00] <= 32'hCAFE_F00D;
      mem[7'h13] <= 32'h0BAD_F00D;
      bus_if.Read_data <= '0;
    end else begin
      if (bus_if.MemWrite) mem[{bus_if.Address[30], bus_if.Address[5:0]}] <= bus_if.Write_data;
      if (bus_if.MemRead)  bus_if.Read_data <= mem[{bus_if.Address[30], bus_if.Address[5:0]}];
    end
  end

  // strobe monitor
  int wr_cnt = 0, rd_cnt = 0, ovl_err = 0, stab_err = 0;
  logic [31:0] wr_addr, wr_data, rd_addr, prev_addr, prev_wd;
  logic wr_peri, rd_peri;
  always @(negedge clk) begin
    if (bus_if.MemWrite) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus_if.Address;
      wr_data <= bus_if.Write_data;
      wr_peri <= bus_if.peri_addr;
      if (bus_if.Address !== prev_addr || bus_if.Write_data !== prev_wd) stab_err <= stab_err + 1;
    end
    if (bus_if.MemRead) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= bus_if.Address;
      rd_peri <= bus_if.peri_addr;
      if (bus_if.Address !== prev_addr) stab_err <= stab_err + 1;
    end
    if (bus_if.MemRead && bus_if.MemWrite) ovl_err <= ovl_err + 1;
    prev_addr <= bus_if.Address;
    prev_wd   <= bus_if.Write_data;
  end

  // tx decoder: byte values and start cycles
  logic [7:0] rxq [$];
  int         stq [$];
  initial begin
    forever begin
      int st;
      logic [7:0] b;
      @(negedge tx);
      st = cyc;
      b = '0;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      rxq.push_back(b);
      stq.push_back(st);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good_stop;
    repeat (CPB) @(negedge clk);
    if (!good_stop) begin
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1);
  endtask

  // bounded waits; caller checks ok
  task automatic wait_bytes(input int n, output bit ok);
    int k = 0;
    while (rxq.size() < n && k < 4000) begin
      @(negedge clk);
      k++;
    end
    ok = (rxq.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int k = 0;
    while (busy !== 1'b0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus_if.MemRead !== 1'b0) begin errors++; $display("FAIL reset_memread: got %b want 0", bus_if.MemRead); end
    checks++; if (bus_if.MemWrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite: got %b want 0", bus_if.MemWrite); end
    checks++; if (bus_if.Address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus_if.Address); end
    checks++; if (bus_if.Write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus_if.Write_data); end
    checks++; if (bus_if.peri_addr !== 1'b0) begin errors++; $display("FAIL reset_peri: got %b want 0", bus_if.peri_addr); end
  endtask

  task automatic test_write();
    bit ok;
    int w0 = wr_cnt, r0 = rd_cnt;
    rxq.delete(); stq.delete();
    send_write(32'h0000_0010, 32'hDEAD_BEEF);
    wait_bytes(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_resp_timeout: got %0d bytes want 1", rxq.size()); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_idle: busy=%b want 0", busy); end
    checks++; if (rxq.size() != 1 || rxq[0] !== 8'h4B) begin errors++; $display("FAIL write_ack: got %h (n=%0d) want 4b", rxq[0], rxq.size()); end
    checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL write_pulses: got %0d want 1", wr_cnt - w0); end
    checks++; if (rd_cnt - r0 != 0) begin errors++; $display("FAIL write_no_read: got %0d want 0", rd_cnt - r0); end
    checks++; if (wr_addr !== 32'h10) begin errors++; $display("FAIL write_addr: got %h want 00000010", wr_addr); end
    checks++; if (wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_data: got %h want deadbeef", wr_data); end
    checks++; if (wr_peri !== 1'b0) begin errors++; $display("FAIL write_peri: got %b want 0", wr_peri); end
  endtask

  task automatic test_read();
    bit ok;
    logic [31:0] w = 32'hDEAD_BEEF;
    int r0 = rd_cnt;
    rxq.delete(); stq.delete();
    send_read(32'h0000_0010);
    wait_bytes(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_resp_timeout: got %0d bytes want 4", rxq.size()); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_idle: busy=%b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rxq[i] !== w[31-8*i -: 8]) begin errors++; $display("FAIL read_byte%0d: got %h want %h", i, rxq[i], w[31-8*i -: 8]); end
    end
    checks++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL read_pulses: got %0d want 1", rd_cnt - r0); end
    checks++; if (rd_addr !== 32'h10) begin errors++; $display("FAIL read_addr: got %h want 00000010", rd_addr); end
    checks++; if (stq[1] - stq[0] != BYTE_CLKS) begin errors++; $display("FAIL read_gap: got %0d want %0d", stq[1] - stq[0], BYTE_CLKS); end
    checks++; if (stq[3] - stq[0] != 3 * BYTE_CLKS) begin errors++; $display("FAIL read_span: got %0d want %0d", stq[3] - stq[0], 3 * BYTE_CLKS); end
  endtask

  task automatic test_peri_read();
    bit ok;
    logic [31:0] w = 32'h1234_5678;
    rxq.delete(); stq.delete();
    send_read(32'h4000_000C);
    wait_bytes(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL peri_timeout: got %0d bytes want 4", rxq.size()); end
    wait_idle(ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rxq[i] !== w[31-8*i -: 8]) begin errors++; $display("FAIL peri_byte%0d: got %h want %h", i, rxq[i], w[31-8*i -: 8]); end
    end
    checks++; if (rd_peri !== 1'b1) begin errors++; $display("FAIL peri_flag: got %b want 1", rd_peri); end
    checks++; if (rd_addr !== 32'h4000_000C) begin errors++; $display("FAIL peri_addr: got %h want 4000000c", rd_addr); end
  endtask

  task automatic test_unaligned();
    bit ok;
    logic [31:0] w = 32'h0BAD_F00D;
    rxq.delete(); stq.delete();
    send_read(32'h0000_0013);
    wait_bytes(4, ok);
    wait_idle(ok);
    checks++; if (rd_addr !== 32'h13) begin errors++; $display("FAIL unaligned_addr: got %h want 00000013", rd_addr); end
    checks++; if ({rxq[0], rxq[1], rxq[2], rxq[3]} !== w) begin errors++; $display("FAIL unaligned_data: got %h%h%h%h want %h", rxq[0], rxq[1], rxq[2], rxq[3], w); end
  endtask

  task automatic test_bad_opcode();
    bit ok;
    int w0 = wr_cnt, r0 = rd_cnt;
    rxq.delete(); stq.delete();
    send_byte(8'h41, 1'b1);
    wait_bytes(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL badop_timeout: got %0d bytes want 1", rxq.size()); end
    wait_idle(ok);
    checks++; if (rxq.size() != 1 || rxq[0] !== 8'h3F) begin errors++; $display("FAIL badop_resp: got %h (n=%0d) want 3f", rxq[0], rxq.size()); end
    checks++; if (wr_cnt != w0 || rd_cnt != r0) begin errors++; $display("FAIL badop_strobe: got wr=%0d rd=%0d want 0 0", wr_cnt - w0, rd_cnt - r0); end
  endtask

  task automatic test_timeout();
    bit ok;
    int w0 = wr_cnt, r0 = rd_cnt;
    rxq.delete(); stq.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_mid: got %b want 1", busy); end
    repeat (2500) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_abort: busy=%b want 0", busy); end
    send_read(32'h0000_0000);
    wait_bytes(4, ok);
    wait_idle(ok);
    checks++; if ({rxq[0], rxq[1], rxq[2], rxq[3]} !== 32'hCAFE_F00D || rxq.size() != 4) begin errors++; $display("FAIL timeout_read: got %h%h%h%h (n=%0d) want cafef00d", rxq[0], rxq[1], rxq[2], rxq[3], rxq.size()); end
    checks++; if (wr_cnt != w0) begin errors++; $display("FAIL timeout_nowrite: got %0d want 0", wr_cnt - w0); end
    checks++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL timeout_readcnt: got %0d want 1", rd_cnt - r0); end
  endtask

  task automatic test_framing();
    bit ok;
    int r0 = rd_cnt;
    rxq.delete(); stq.delete();
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL framing_abort: busy=%b want 0", busy); end
    send_read(32'h0000_0010);
    wait_bytes(4, ok);
    wait_idle(ok);
    checks++; if ({rxq[0], rxq[1], rxq[2], rxq[3]} !== 32'hDEAD_BEEF || rxq.size() != 4) begin errors++; $display("FAIL framing_read: got %h%h%h%h (n=%0d) want deadbeef", rxq[0], rxq[1], rxq[2], rxq[3], rxq.size()); end
    checks++; if (rd_cnt - r0 != 1 || rd_addr !== 32'h10) begin errors++; $display("FAIL framing_strobe: got n=%0d addr=%h want 1 00000010", rd_cnt - r0, rd_addr); end
  endtask

  task automatic test_reset_mid_tx();
    int k = 0;
    int w0, r0;
    rxq.delete(); stq.delete();
    send_read(32'h0000_0010);
    while (tx !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b want 0", tx); end
    repeat (2 * CPB + CPB / 2) @(negedge clk);
    w0 = wr_cnt; r0 = rd_cnt;
    reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx_high: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (bus_if.Address !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus_if.Address); end
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_after: got tx=%b busy=%b want 1 0", tx, busy); end
    checks++; if (wr_cnt != w0 || rd_cnt != r0) begin errors++; $display("FAIL rst_strobes: got wr=%0d rd=%0d want 0 0", wr_cnt - w0, rd_cnt - r0); end
    rxq.delete(); stq.delete();
  endtask

  task automatic test_bus_rules();
    checks++; if (ovl_err != 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", ovl_err); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL addr_setup: got %0d want 0", stab_err); end
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    test_write();
    test_read();
    test_peri_read();
    test_unaligned();
    test_bad_opcode();
    test_timeout();
    test_framing();
    test_reset_mid_tx();
    test_bus_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
